// File: rtl/riscv_if_pkg.sv
// Shared IF/ID/EX constants: NOP encoding, control-flow opcodes,
// RVC quadrant/funct3 codes and a control-flow classifier.
package riscv_if_pkg;

    localparam logic [31:0] NOP           = 32'h0000_0013;

    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;

    localparam logic [1:0]  RVC_OP_C1     = 2'b01;
    localparam logic [1:0]  RVC_OP_C2     = 2'b10;

    localparam logic [2:0]  RVC_F3_BEQZ   = 3'b110;
    localparam logic [2:0]  RVC_F3_BNEZ   = 3'b111;
    localparam logic [2:0]  RVC_F3_J      = 3'b101;
    localparam logic [2:0]  RVC_F3_JAL    = 3'b001;
    localparam logic [2:0]  RVC_F3_JR     = 3'b100;

    // True when the instruction can change control flow.
    function automatic logic is_cf(input logic [31:0] inst,
                                   input logic        compressed);
        logic r;
        r = 1'b0;
        if (!compressed) begin
            r = (inst[6:0] == OPCODE_BRANCH) ||
                (inst[6:0] == OPCODE_JAL)    ||
                (inst[6:0] == OPCODE_JALR);
        end else if (inst[1:0] == RVC_OP_C1) begin
            r = (inst[15:13] == RVC_F3_BEQZ) ||
                (inst[15:13] == RVC_F3_BNEZ) ||
                (inst[15:13] == RVC_F3_J)    ||
                (inst[15:13] == RVC_F3_JAL);
        end else if (inst[1:0] == RVC_OP_C2) begin
            r = (inst[15:13] == RVC_F3_JR) && (inst[6:2] == 5'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Generic DEPTH x W synchronous FIFO with clear, occupancy count
// and full/empty flags. Head storage is visible even when empty.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign rd_data = r_mem[r_rptr];
    assign count   = r_count;

    // Storage, pointers and count; clear drops entries but keeps storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

endmodule

// File: rtl/riscv_if_fetch_queue.sv
// Instruction fetch stage: next-PC selection (redirect / prediction /
// sequential) feeding a queue that decouples fetch from decode.
module riscv_if_fetch_queue
    import riscv_if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter bit              PRED_EN  = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [XLEN-1:0]            fetch_inst,
    input  logic                       fetch_compressed,
    output logic [XLEN-1:0]            fetch_pc,
    input  logic                       bp_taken,
    input  logic [XLEN-1:0]            bp_target,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [XLEN-1:0]            deq_inst,
    output logic [XLEN-1:0]            deq_pc,
    output logic                       deq_compressed,
    output logic [XLEN-1:0]            deq_pred_dest,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int W = 3*XLEN + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_pred_next;
    logic            w_is_cf;
    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;
    logic [W-1:0]    w_wr_data;
    logic [W-1:0]    w_head;
    logic [XLEN-1:0] w_head_pc;
    logic [XLEN-1:0] w_head_inst;
    logic            w_head_c;
    logic [XLEN-1:0] w_head_pred;

    assign w_is_cf     = is_cf(fetch_inst[31:0], fetch_compressed);
    assign w_step      = r_pc + (fetch_compressed ? XLEN'(2) : XLEN'(4));
    assign w_pred_next = (PRED_EN && bp_taken && w_is_cf) ? bp_target
                                                          : w_step;
    assign w_enq       = fetch_valid && !w_full && !redirect;
    assign w_deq       = !w_empty && deq_ready;
    assign w_wr_data   = {r_pc, fetch_inst, fetch_compressed, w_pred_next};

    assign {w_head_pc, w_head_inst, w_head_c, w_head_pred} = w_head;

    if_fetch_queue #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clr     (redirect),
        .wr_en   (w_enq),
        .wr_data (w_wr_data),
        .rd_en   (w_deq && !redirect),
        .rd_data (w_head),
        .count   (q_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Fetch PC: redirect overrides, otherwise advance only on enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (w_enq) begin
            r_pc <= w_pred_next;
        end
    end

    assign fetch_pc       = r_pc;
    assign deq_valid      = !w_empty;
    assign deq_inst       = w_empty ? XLEN'(NOP) : w_head_inst;
    assign deq_compressed = !w_empty && w_head_c;
    assign deq_pc         = w_head_pc;
    assign deq_pred_dest  = w_head_pred;

endmodule
